universal_shift_register: RTL and testbench

//  Parametrised successor to the 8-bit serial-in shift register: WIDTH-bit universal register

---
 rtl/shift_reg_pkg.sv | 20 ++
 rtl/universal_shift_register_if.sv | 38 +++
 rtl/shift_frame_counter.sv | 34 +++
 rtl/universal_shift_register.sv | 65 ++++++
 tb/tb_universal_shift_register.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_pkg.sv
// Mode encoding and sizing helpers shared by the universal shift register
// and the controllers that drive it.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic int unsigned count_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic logic is_shift(input mode_e mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register; the rotate request
// exists only when SHIFT_REG_ROTATE_EN is defined.
interface universal_shift_register_if
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = count_width(WIDTH);

  mode_e            mode;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
`ifdef SHIFT_REG_ROTATE_EN
  logic             rotate;
`endif
  logic [WIDTH-1:0] stored_data;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic [CW-1:0]    shift_count;
  logic             frame_done;

  modport master (
`ifdef SHIFT_REG_ROTATE_EN
    output rotate,
`endif
    output mode, serial_in, parallel_in,
    input  stored_data, serial_out_msb, serial_out_lsb, shift_count, frame_done
  );

  modport slave (
`ifdef SHIFT_REG_ROTATE_EN
    input  rotate,
`endif
    input  mode, serial_in, parallel_in,
    output stored_data, serial_out_msb, serial_out_lsb, shift_count, frame_done
  );

endinterface

// File: rtl/shift_frame_counter.sv
// Counts shifts within a WIDTH-bit frame and pulses frame_done for the one
// cycle after the frame-completing shift; a load clears a partial frame.
module shift_frame_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          frame_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else if (shift) begin
      if (count == LAST) begin
        count      <= '0;
        frame_done <= 1'b1;
      end else begin
        count      <= count + CW'(1);
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift-left/shift-right/load register with serial taps and
// frame counter. Define SHIFT_REG_ROTATE_EN to add recirculating shifts.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                       clk,
  input logic                       reset,
  universal_shift_register_if.slave bus
);

  localparam int unsigned CW = count_width(WIDTH);

  logic [WIDTH-1:0] data;
  logic             in_left;
  logic             in_right;
  logic [CW-1:0]    count;
  logic             frame_done;

  always_comb begin
    in_left  = bus.serial_in;
    in_right = bus.serial_in;
`ifdef SHIFT_REG_ROTATE_EN
    // Rotation feeds back the bit leaving the opposite end.
    if (bus.rotate) begin
      in_left  = data[WIDTH-1];
      in_right = data[0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else begin
      case (bus.mode)
        MODE_SHL:  data <= {data[WIDTH-2:0], in_left};
        MODE_SHR:  data <= {in_right, data[WIDTH-1:1]};
        MODE_LOAD: data <= bus.parallel_in;
        default:   data <= data;
      endcase
    end
  end

  shift_frame_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .shift      (is_shift(bus.mode)),
    .clear      (bus.mode == MODE_LOAD),
    .count      (count),
    .frame_done (frame_done)
  );

  assign bus.stored_data    = data;
  assign bus.serial_out_msb = data[WIDTH-1];
  assign bus.serial_out_lsb = data[0];
  assign bus.shift_count    = count;
  assign bus.frame_done     = frame_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register: two instances (reset values
// 8'h00 and 8'hFF) driven in lockstep and compared against an arithmetic model.
module tb_universal_shift_register;
  import shift_reg_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned FULL = 1 << W;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(W)) bus0 ();
  universal_shift_register_if #(.WIDTH(W)) bus1 ();

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(8'hFF)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    int unsigned d0;
    int unsigned d1;
    int unsigned cnt;
    int unsigned fd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned m_d0, m_d1, m_cnt, m_fd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned next_data(input int unsigned d, input int unsigned mode,
                                            input int unsigned sin, input int unsigned pin,
                                            input int unsigned rot);
    int unsigned b;
    case (mode)
      1: begin
        b = (rot != 0) ? (d / (FULL / 2)) : sin;
        return (d * 2 + b) % FULL;
      end
      2: begin
        b = (rot != 0) ? (d % 2) : sin;
        return d / 2 + b * (FULL / 2);
      end
      3:       return pin % FULL;
      default: return d;
    endcase
  endfunction

  task automatic step(input bit rst, input int unsigned mode, input int unsigned sin,
                      input int unsigned pin, input int unsigned rot);
    int unsigned eff_rot;
    eff_rot          = ROT_EN ? rot : 0;
    reset            = rst;
    bus0.mode        = mode_e'(mode[1:0]);
    bus1.mode        = mode_e'(mode[1:0]);
    bus0.serial_in   = sin[0];
    bus1.serial_in   = sin[0];
    bus0.parallel_in = pin[W-1:0];
    bus1.parallel_in = pin[W-1:0];
`ifdef SHIFT_REG_ROTATE_EN
    bus0.rotate = rot[0];
    bus1.rotate = rot[0];
`endif
    if (rst) begin
      m_d0  = 0;
      m_d1  = FULL - 1;
      m_cnt = 0;
      m_fd  = 0;
    end else begin
      m_d0 = next_data(m_d0, mode, sin, pin, eff_rot);
      m_d1 = next_data(m_d1, mode, sin, pin, eff_rot);
      if (mode == 1 || mode == 2) begin
        m_cnt++;
        m_fd = (m_cnt == W) ? 1 : 0;
        if (m_cnt == W) m_cnt = 0;
      end else begin
        m_fd = 0;
        if (mode == 3) m_cnt = 0;
      end
    end
    sb.push_back('{m_d0, m_d1, m_cnt, m_fd});
    @(negedge clk);
  endtask

  // Monitor: every cycle after the edge, compare outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stored_data", bus0.stored_data, e.d0);
        chk("stored_data_rv_ff", bus1.stored_data, e.d1);
        chk("serial_out_msb", bus0.serial_out_msb, e.d0 / (FULL / 2));
        chk("serial_out_lsb", bus0.serial_out_lsb, e.d0 % 2);
        chk("serial_out_lsb_rv_ff", bus1.serial_out_lsb, e.d1 % 2);
        chk("shift_count", bus0.shift_count, e.cnt);
        chk("shift_count_rv_ff", bus1.shift_count, e.cnt);
        chk("frame_done", bus0.frame_done, e.fd);
        chk("frame_done_rv_ff", bus1.frame_done, e.fd);
      end
    end
  end

  initial begin
    int unsigned shl_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int unsigned r, mode;

    reset            = 1'b1;
    bus0.mode        = MODE_HOLD;
    bus1.mode        = MODE_HOLD;
    bus0.serial_in   = 1'b0;
    bus1.serial_in   = 1'b0;
    bus0.parallel_in = '0;
    bus1.parallel_in = '0;
`ifdef SHIFT_REG_ROTATE_EN
    bus0.rotate = 1'b0;
    bus1.rotate = 1'b0;
`endif
    @(negedge clk);

    // Reset then hold.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h5A, 0);
    chk("hold_data", bus0.stored_data, 8'h00);
    chk("hold_data_rv_ff", bus1.stored_data, 8'hFF);
    chk("hold_count", bus0.shift_count, 0);

    // Shift-left frame.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, shl_bits[i], 0, 0);
      if (i == 6) chk("shl_no_early_done", bus0.frame_done, 0);
    end
    chk("shl_data", bus0.stored_data, 8'hB2);
    chk("shl_frame_done", bus0.frame_done, 1);
    chk("shl_count_wrap", bus0.shift_count, 0);
    step(0, 0, 0, 0, 0);
    chk("shl_done_pulse_end", bus0.frame_done, 0);

    // Load then partial right-shift frame.
    step(0, 3, 0, 8'hA5, 0);
    for (int i = 0; i < 4; i++) step(0, 2, 0, 0, 0);
    chk("shr_data", bus0.stored_data, 8'h0A);
    chk("shr_lsb", bus0.serial_out_lsb, 0);
    chk("shr_count", bus0.shift_count, 4);
    chk("shr_no_done", bus0.frame_done, 0);

    // Load aborts the partial frame.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(0, 3, 0, 8'h3C, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2 == 0) ? 1 : 2, i % 2, 0, 0);
      if (i < 7) chk("load_abort_no_done", bus0.frame_done, 0);
    end
    chk("load_abort_done", bus0.frame_done, 1);

    // Back-to-back frames.
    for (int i = 0; i < 2 * W; i++) step(0, 2, $urandom % 2, 0, 0);
    chk("b2b_done", bus0.frame_done, 1);

    // Mid-frame reset.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("midreset_data", bus0.stored_data, 8'h00);
    chk("midreset_data_rv_ff", bus1.stored_data, 8'hFF);
    chk("midreset_count", bus0.shift_count, 0);
    chk("midreset_no_done", bus0.frame_done, 0);

`ifdef SHIFT_REG_ROTATE_EN
    step(0, 3, 0, 8'h81, 0);
    step(0, 1, 0, 0, 1);
    chk("rotl_data", bus0.stored_data, 8'h03);
    step(0, 2, 0, 0, 1);
    step(0, 2, 0, 0, 1);
    chk("rotr_data", bus0.stored_data, 8'hC0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r    = $urandom % 16;
      mode = (r < 2) ? 0 : (r < 8) ? 1 : (r < 14) ? 2 : 3;
      step(($urandom % 48) == 0, mode, $urandom % 2, $urandom % 256, $urandom % 2);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
